// File: rtl/ssk_pkg.sv
// ssk_pkg: shared definitions for the multi-slot session-key control unit.
//   - Opcode constants carried in cmd_op[7:4].
//   - Response error codes reported on resp_err.
//   - One-hot FSM state encodings.
package ssk_pkg;

  localparam logic [3:0] OP_READ  = 4'd0;
  localparam logic [3:0] OP_WRITE = 4'd1;
  localparam logic [3:0] OP_ERASE = 4'd2;
  localparam logic [3:0] OP_LOCK  = 4'd3;

  typedef enum logic [2:0] {
    ERR_OK      = 3'd0,
    ERR_CMD     = 3'd1,
    ERR_SIZE    = 3'd2,
    ERR_STATE   = 3'd3,
    ERR_TIMEOUT = 3'd4
  } err_e;

  typedef enum logic [5:0] {
    S_IDLE    = 6'b000001,
    S_CHECK   = 6'b000010,
    S_RD_XFER = 6'b000100,
    S_WR_XFER = 6'b001000,
    S_DONE    = 6'b010000,
    S_ERR     = 6'b100000
  } state_e;

endpackage

// File: rtl/ssk_beat_cnt.sv
// ssk_beat_cnt: byte countdown and inactivity watchdog for one transfer.
//   clk, rst      : clock, synchronous active-high reset
//   load,load_val : load the transfer length in bytes
//   beat          : one accepted beat of the active transfer
//   run           : a transfer state is active (watchdog counts idle cycles)
//   rem_zero      : no bytes remain
//   rem_last      : the next beat finishes the transfer
//   wd_expired    : watchdog has reached TIMEOUT-1 idle cycles
module ssk_beat_cnt #(
  parameter int BEAT_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        beat,
  input  logic        run,
  output logic        rem_zero,
  output logic        rem_last,
  output logic        wd_expired
);

  localparam int              WD_W   = $clog2(TIMEOUT);
  localparam logic [15:0]     BEAT   = 16'(BEAT_BYTES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

  logic [15:0]     rem_q, rem_d;
  logic [WD_W-1:0] wd_q, wd_d;

  assign rem_zero   = (rem_q == '0);
  assign rem_last   = (rem_q <= BEAT);
  assign wd_expired = (wd_q == WD_MAX);

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rem_d = rem_q;
    if (load) begin
      rem_d = load_val;
    end else if (beat) begin
      // Saturate at zero: a short final beat never wraps the count.
      rem_d = rem_last ? '0 : rem_q - BEAT;
    end
    // Idle cycles inside a transfer advance the watchdog; a beat or any
    // non-transfer cycle (including the loading CHECK cycle) clears it.
    wd_d = (run && !beat) ? wd_q + 1'b1 : '0;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q <= '0;
      wd_q  <= '0;
    end else begin
      rem_q <= rem_d;
      wd_q  <= wd_d;
    end
  end

endmodule

// File: rtl/ssk_slot_cu.sv
// ssk_slot_cu: multi-slot session-key control unit.
// Decodes read/write/erase/lock commands against NUM_SLOTS key slots, checks
// sizes and slot state, tracks transfer beats with an inactivity watchdog and
// keeps per-slot valid/lock bits.
//   clk, rst            : clock, synchronous active-high reset
//   clr_ssk, ss_expire  : abort to IDLE (clr_ssk also wipes all slot bits)
//   cmd_rdy, cmd_en     : command handshake, sampled in IDLE only
//   cmd_op              : [7:4] opcode, [3:0] slot index
//   cmd_extend, wr_size : read / write length in bytes
//   wr_en, rd_en        : write / read beats
//   wr_open, rd_open    : transfer windows
//   slot_sel            : latched slot index
//   slot_valid/lock     : per-slot key-present / write-protect bits
//   resp_done, resp_err : one-cycle response and its error code
module ssk_slot_cu
  import ssk_pkg::*;
#(
  parameter int NUM_SLOTS  = 4,
  parameter int SLOT_BYTES = 64,
  parameter int BEAT_BYTES = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr_ssk,
  input  logic                         ss_expire,
  output logic                         cmd_rdy,
  input  logic                         cmd_en,
  input  logic [7:0]                   cmd_op,
  input  logic [15:0]                  cmd_extend,
  input  logic [15:0]                  wr_size,
  input  logic                         wr_en,
  input  logic                         rd_en,
  output logic                         wr_open,
  output logic                         rd_open,
  output logic [$clog2(NUM_SLOTS)-1:0] slot_sel,
  output logic [NUM_SLOTS-1:0]         slot_valid,
  output logic [NUM_SLOTS-1:0]         slot_lock,
  output logic                         resp_done,
  output logic [2:0]                   resp_err
);

  localparam int          SEL_W    = $clog2(NUM_SLOTS);
  localparam logic [15:0] SLOT_MAX = 16'(SLOT_BYTES);
  localparam logic [4:0]  SLOT_CNT = 5'(NUM_SLOTS);

  state_e               state_q, state_d;
  err_e                 err_code_q, err_code_d;
  logic [3:0]           op_q, op_d;
  logic [3:0]           slot_q, slot_d;
  logic [15:0]          ext_q, ext_d;
  logic [15:0]          size_q, size_d;
  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] lock_q, lock_d;
  logic [NUM_SLOTS-1:0] slot_mask;

  logic        load, beat, run;
  logic [15:0] load_val;
  logic        rem_zero, rem_last, wd_expired;
  logic        sel_valid, sel_locked;
  logic        ext_nz, size_nz;

  // Moore outputs decoded straight from the registered one-hot state.
  assign cmd_rdy    = (state_q == S_IDLE);
  assign wr_open    = (state_q == S_WR_XFER);
  assign rd_open    = (state_q == S_RD_XFER);
  assign resp_done  = (state_q == S_DONE) || (state_q == S_ERR);
  assign resp_err   = (state_q == S_ERR) ? err_code_q : ERR_OK;
  assign slot_sel   = slot_q[SEL_W-1:0];
  assign slot_valid = valid_q;
  assign slot_lock  = lock_q;

  // Empty mask for an out-of-range slot; only consulted after the range check.
  assign slot_mask  = {{(NUM_SLOTS-1){1'b0}}, 1'b1} << slot_q;
  assign sel_valid  = |(valid_q & slot_mask);
  assign sel_locked = |(lock_q & slot_mask);
  assign ext_nz     = (ext_q != '0);
  assign size_nz    = (size_q != '0);
  assign load_val   = (op_q == OP_READ) ? ext_q : size_q;

  ssk_beat_cnt #(
    .BEAT_BYTES (BEAT_BYTES),
    .TIMEOUT    (TIMEOUT)
  ) u_beat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_val   (load_val),
    .beat       (beat),
    .run        (run),
    .rem_zero   (rem_zero),
    .rem_last   (rem_last),
    .wd_expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    op_d       = op_q;
    slot_d     = slot_q;
    ext_d      = ext_q;
    size_d     = size_q;
    valid_d    = valid_q;
    lock_d     = lock_q;
    load       = 1'b0;
    beat       = 1'b0;
    run        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_en) begin
          op_d    = cmd_op[7:4];
          slot_d  = cmd_op[3:0];
          ext_d   = cmd_extend;
          size_d  = wr_size;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        state_d = S_ERR;
        if (op_q > OP_LOCK || {1'b0, slot_q} >= SLOT_CNT) begin
          err_code_d = ERR_CMD;
        end else begin
          case (op_q)
            OP_READ: begin
              if (size_nz || !ext_nz || ext_q > SLOT_MAX) begin
                err_code_d = ERR_SIZE;
              end else if (!sel_valid) begin
                err_code_d = ERR_STATE;
              end else begin
                load    = 1'b1;
                state_d = S_RD_XFER;
              end
            end
            OP_WRITE: begin
              if (ext_nz || !size_nz || size_q > SLOT_MAX) begin
                err_code_d = ERR_SIZE;
              end else if (sel_locked) begin
                err_code_d = ERR_STATE;
              end else begin
                // The old key is gone as soon as a rewrite starts.
                valid_d = valid_q & ~slot_mask;
                load    = 1'b1;
                state_d = S_WR_XFER;
              end
            end
            OP_ERASE: begin
              if (ext_nz || size_nz) begin
                err_code_d = ERR_SIZE;
              end else if (sel_locked) begin
                err_code_d = ERR_STATE;
              end else begin
                valid_d = valid_q & ~slot_mask;
                state_d = S_DONE;
              end
            end
            default: begin // OP_LOCK
              if (ext_nz || size_nz) begin
                err_code_d = ERR_SIZE;
              end else if (!sel_valid) begin
                err_code_d = ERR_STATE;
              end else begin
                lock_d  = lock_q | slot_mask;
                state_d = S_DONE;
              end
            end
          endcase
        end
      end

      S_RD_XFER: begin
        run  = 1'b1;
        beat = rd_en;
        if (rem_zero || (beat && rem_last)) begin
          state_d = S_DONE;
        end else if (!beat && wd_expired) begin
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end

      S_WR_XFER: begin
        run  = 1'b1;
        beat = wr_en;
        if (rem_zero || (beat && rem_last)) begin
          valid_d = valid_q | slot_mask;
          state_d = S_DONE;
        end else if (!beat && wd_expired) begin
          // Slot was cleared in CHECK and stays invalid after the abort.
          err_code_d = ERR_TIMEOUT;
          state_d    = S_ERR;
        end
      end

      default: begin // S_DONE, S_ERR
        state_d = S_IDLE;
      end
    endcase

    // Aborts override every transition above, including a final beat.
    // Restoring the registered slot bits on ss_expire cancels any update this
    // cycle; an in-flight write slot is already invalid from CHECK.
    if (clr_ssk) begin
      state_d = S_IDLE;
      valid_d = '0;
      lock_d  = '0;
      load    = 1'b0;
      beat    = 1'b0;
      run     = 1'b0;
    end else if (ss_expire) begin
      state_d = S_IDLE;
      valid_d = valid_q;
      lock_d  = lock_q;
      load    = 1'b0;
      beat    = 1'b0;
      run     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      err_code_q <= ERR_OK;
      op_q       <= '0;
      slot_q     <= '0;
      ext_q      <= '0;
      size_q     <= '0;
      valid_q    <= '0;
      lock_q     <= '0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
      op_q       <= op_d;
      slot_q     <= slot_d;
      ext_q      <= ext_d;
      size_q     <= size_d;
      valid_q    <= valid_d;
      lock_q     <= lock_d;
    end
  end

endmodule

// File: tb/tb_ssk_slot_cu.sv
// tb_ssk_slot_cu: self-checking bench for ssk_slot_cu.
// Directed scenarios followed by randomized commands, all predicted by a
// command-level model of the slot table (valid/lock vectors plus byte counts).
module tb_ssk_slot_cu;

  localparam int NS = 4;
  localparam int SB = 64;
  localparam int BB = 4;
  localparam int TO = 16;

  localparam int RD_GO = -1;
  localparam int WR_GO = -2;

  logic          clk = 1'b0;
  logic          rst, clr_ssk, ss_expire;
  logic          cmd_rdy, cmd_en;
  logic [7:0]    cmd_op;
  logic [15:0]   cmd_extend, wr_size;
  logic          wr_en, rd_en, wr_open, rd_open;
  logic [1:0]    slot_sel;
  logic [NS-1:0] slot_valid, slot_lock;
  logic          resp_done;
  logic [2:0]    resp_err;

  int n_asserts = 0;
  int n_fails   = 0;

  // Model of the slot table.
  logic [NS-1:0] mvalid = '0;
  logic [NS-1:0] mlock  = '0;

  ssk_slot_cu #(
    .NUM_SLOTS  (NS),
    .SLOT_BYTES (SB),
    .BEAT_BYTES (BB),
    .TIMEOUT    (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .clr_ssk    (clr_ssk),
    .ss_expire  (ss_expire),
    .cmd_rdy    (cmd_rdy),
    .cmd_en     (cmd_en),
    .cmd_op     (cmd_op),
    .cmd_extend (cmd_extend),
    .wr_size    (wr_size),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .wr_open    (wr_open),
    .rd_open    (rd_open),
    .slot_sel   (slot_sel),
    .slot_valid (slot_valid),
    .slot_lock  (slot_lock),
    .resp_done  (resp_done),
    .resp_err   (resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed no end of test, required end within 2ms");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outcome of a command from the slot table rules: an error code (0 = OK for
  // erase/lock) or RD_GO/WR_GO when a transfer opens.
  function automatic int expect_cmd(input int op, input int slot, input int ext, input int size);
    if (op > 3 || slot >= NS) return 1;
    case (op)
      0: begin
        if (size != 0 || ext == 0 || ext > SB) return 2;
        if (!mvalid[2'(slot)]) return 3;
        return RD_GO;
      end
      1: begin
        if (ext != 0 || size == 0 || size > SB) return 2;
        if (mlock[2'(slot)]) return 3;
        return WR_GO;
      end
      2: begin
        if (ext != 0 || size != 0) return 2;
        if (mlock[2'(slot)]) return 3;
        return 0;
      end
      default: begin
        if (ext != 0 || size != 0) return 2;
        if (!mvalid[2'(slot)]) return 3;
        return 0;
      end
    endcase
  endfunction

  // Issue a command in IDLE and follow it to its response or open window.
  task automatic start_cmd(input int op, input int slot, input int ext, input int size,
                           input string tag, output int exp);
    exp = expect_cmd(op, slot, ext, size);
    check({tag, "/rdy"}, cmd_rdy, 1);
    cmd_en     = 1'b1;
    cmd_op     = {4'(op), 4'(slot)};
    cmd_extend = 16'(ext);
    wr_size    = 16'(size);
    tick();
    // Scramble inputs: the unit must work from its latched copy.
    cmd_en     = 1'b0;
    cmd_op     = 8'($urandom);
    cmd_extend = 16'($urandom);
    wr_size    = 16'($urandom);
    check({tag, "/in_check"}, cmd_rdy, 0);
    tick();
    if (exp >= 0) begin
      check({tag, "/resp_done"}, resp_done, 1);
      check({tag, "/resp_err"}, resp_err, exp);
      if (exp == 0 && op == 2) mvalid[2'(slot)] = 1'b0;
      if (exp == 0 && op == 3) mlock[2'(slot)]  = 1'b1;
      tick();
      check({tag, "/done_drop"}, resp_done, 0);
      check({tag, "/rdy_back"}, cmd_rdy, 1);
      check({tag, "/valid"}, slot_valid, mvalid);
      check({tag, "/lock"}, slot_lock, mlock);
    end else begin
      if (exp == WR_GO) mvalid[2'(slot)] = 1'b0;
      check({tag, "/open"}, (exp == WR_GO) ? wr_open : rd_open, 1);
      check({tag, "/slot_sel"}, slot_sel, slot);
      check({tag, "/valid_open"}, slot_valid, mvalid);
      check({tag, "/no_done"}, resp_done, 0);
    end
  endtask

  // Run the beats of an open transfer with short random gaps and noise on
  // the inputs that must be ignored.
  task automatic finish_xfer(input bit is_wr, input int slot, input int bytes, input string tag);
    int left;
    left = bytes;
    while (left > 0) begin
      repeat ($urandom_range(0, 3)) begin
        cmd_en = 1'($urandom);
        cmd_op = 8'($urandom);
        if (is_wr) rd_en = 1'($urandom);
        else       wr_en = 1'($urandom);
        tick();
        check({tag, "/gap_open"}, is_wr ? wr_open : rd_open, 1);
      end
      cmd_en = 1'b0;
      rd_en  = 1'b0;
      wr_en  = 1'b0;
      if (is_wr) wr_en = 1'b1;
      else       rd_en = 1'b1;
      tick();
      wr_en = 1'b0;
      rd_en = 1'b0;
      left  = (left <= BB) ? 0 : left - BB;
      check({tag, "/remaining"}, dut.u_beat_cnt.rem_q, left);
      if (left > 0) begin
        check({tag, "/still_open"}, is_wr ? wr_open : rd_open, 1);
      end else begin
        if (is_wr) mvalid[2'(slot)] = 1'b1;
        check({tag, "/resp_done"}, resp_done, 1);
        check({tag, "/resp_err"}, resp_err, 0);
        check({tag, "/valid_done"}, slot_valid, mvalid);
        tick();
        check({tag, "/rdy_back"}, cmd_rdy, 1);
      end
    end
  endtask

  task automatic do_cmd(input int op, input int slot, input int ext, input int size,
                        input string tag);
    int exp;
    start_cmd(op, slot, ext, size, tag, exp);
    if (exp == WR_GO)      finish_xfer(1'b1, slot, size, tag);
    else if (exp == RD_GO) finish_xfer(1'b0, slot, ext, tag);
  endtask

  task automatic clear_all(input string tag);
    clr_ssk = 1'b1;
    tick();
    clr_ssk = 1'b0;
    mvalid  = '0;
    mlock   = '0;
    check({tag, "/rdy"}, cmd_rdy, 1);
    check({tag, "/valid"}, slot_valid, 0);
    check({tag, "/lock"}, slot_lock, 0);
    check({tag, "/no_done"}, resp_done, 0);
  endtask

  initial begin
    int exp;
    int op, slot, ext, size, r;

    rst = 1'b1; clr_ssk = 1'b0; ss_expire = 1'b0;
    cmd_en = 1'b0; cmd_op = '0; cmd_extend = '0; wr_size = '0;
    wr_en = 1'b0; rd_en = 1'b0;
    repeat (2) tick();
    check("reset/cmd_rdy", cmd_rdy, 1);
    check("reset/outs", {wr_open, rd_open, resp_done, resp_err, slot_sel}, 0);
    check("reset/slots", {slot_valid, slot_lock}, 0);
    rst = 1'b0;
    tick();
    check("reset/idle", cmd_rdy, 1);

    // Directed test plan.
    do_cmd(1, 2, 0, 10, "wr_slot2");
    check("wr_slot2/vector", slot_valid, 4'b0100);
    do_cmd(0, 2, 65, 0, "rd_oversize");
    do_cmd(0, 1, 8, 0, "rd_empty");
    do_cmd(3, 2, 0, 0, "lock2");
    do_cmd(1, 2, 0, 4, "wr_locked");
    check("wr_locked/valid2", slot_valid[2], 1);
    do_cmd(2, 2, 0, 0, "erase_locked");
    do_cmd(5, 0, 0, 0, "bad_op");
    do_cmd(0, 7, 8, 0, "bad_slot");
    do_cmd(0, 2, 10, 0, "rd_slot2");

    // Session expiry mid-read: back to IDLE, no response, slots untouched.
    start_cmd(0, 2, 16, 0, "expire_rd", exp);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    ss_expire = 1'b1; tick(); ss_expire = 1'b0;
    check("expire_rd/rdy", cmd_rdy, 1);
    check("expire_rd/no_done", resp_done, 0);
    check("expire_rd/closed", rd_open, 0);
    check("expire_rd/valid", slot_valid, mvalid);
    check("expire_rd/lock", slot_lock, mlock);

    clear_all("clr1");

    // clr_ssk beats a final write beat in the same cycle.
    start_cmd(1, 1, 0, 4, "clr_vs_beat", exp);
    wr_en = 1'b1; clr_ssk = 1'b1; tick(); wr_en = 1'b0; clr_ssk = 1'b0;
    mvalid = '0; mlock = '0;
    check("clr_vs_beat/no_done", resp_done, 0);
    check("clr_vs_beat/rdy", cmd_rdy, 1);
    check("clr_vs_beat/valid", slot_valid, 0);

    // Watchdog: after one beat the counter reaches TO-1 over TO-1 idle
    // cycles, and the next idle cycle aborts.
    start_cmd(1, 0, 0, 8, "timeout", exp);
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    check("timeout/remaining", dut.u_beat_cnt.rem_q, 4);
    for (int k = 1; k < TO; k++) begin
      tick();
      check($sformatf("timeout/open_%0d", k), {wr_open, resp_done}, 2'b10);
    end
    tick();
    check("timeout/resp_done", resp_done, 1);
    check("timeout/resp_err", resp_err, 4);
    check("timeout/valid", slot_valid, mvalid);
    tick();
    check("timeout/rdy", cmd_rdy, 1);

    // Randomized commands against the model.
    for (int i = 0; i < 60; i++) begin
      r  = $urandom_range(0, 9);
      op = (r == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
      slot = ($urandom_range(0, 7) == 0) ? $urandom_range(4, 15) : $urandom_range(0, NS - 1);
      if (r < 8) begin
        ext  = (op == 0) ? $urandom_range(1, SB) : 0;
        size = (op == 1) ? $urandom_range(1, SB) : 0;
      end else begin
        ext  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, SB + 4);
        size = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, SB + 4);
      end
      do_cmd(op, slot, ext, size, $sformatf("rnd%0d", i));
    end

    clear_all("clr2");

    // Expiry during a rewrite leaves the slot invalid.
    do_cmd(1, 3, 0, 4, "fill3");
    start_cmd(1, 3, 0, 8, "expire_wr", exp);
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    ss_expire = 1'b1; tick(); ss_expire = 1'b0;
    check("expire_wr/rdy", cmd_rdy, 1);
    check("expire_wr/no_done", resp_done, 0);
    check("expire_wr/valid", slot_valid, 4'b0000);

    // Reset in the middle of a write.
    do_cmd(1, 2, 0, 4, "fill2");
    do_cmd(3, 2, 0, 0, "lock2b");
    start_cmd(1, 3, 0, 12, "rst_wr", exp);
    wr_en = 1'b1; tick(); wr_en = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    mvalid = '0; mlock = '0;
    check("rst_wr/cmd_rdy", cmd_rdy, 1);
    check("rst_wr/outs", {wr_open, rd_open, resp_done, resp_err, slot_sel}, 0);
    check("rst_wr/slots", {slot_valid, slot_lock}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule

// File: doc/ssk_slot_cu.md
# ssk_slot_cu

Multi-slot session-key control unit: decodes L3 key commands (read, write, erase, lock) against `NUM_SLOTS` key slots, checks sizes and slot state, and tracks write and read beats. It enforces a per-transfer inactivity timeout and keeps per-slot valid/lock state. It sits between the L3 command parser and the key-storage datapath, and extends the single-slot ssk control unit with slot addressing, read tracking, erase/lock opcodes and a watchdog.

## Interface
- `NUM_SLOTS`, 4: number of key slots, 2..16.
- `SLOT_BYTES`, 64: maximum key size per slot in bytes, 1..65535.
- `BEAT_BYTES`, 4: bytes per `wr_en`/`rd_en` beat, 1..16.
- `TIMEOUT`, 1024: idle cycles allowed in a transfer before abort, ≥2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `clr_ssk` in 1: clear all slots and abort.
- `ss_expire` in 1: session expiry; abort only.
- `cmd_rdy` out 1: high in IDLE.
- `cmd_en` in 1: command strobe, sampled only in IDLE.
- `cmd_op` in 8: [7:4] opcode (0 read, 1 write, 2 erase, 3 lock); [3:0] slot index.
- `cmd_extend` in 16: read length in bytes.
- `wr_size` in 16: write length in bytes.
- `wr_en` in 1: write beat accepted.
- `rd_en` in 1: read beat consumed.
- `wr_open` out 1: high throughout WR_XFER.
- `rd_open` out 1: high throughout RD_XFER.
- `slot_sel` out $clog2(NUM_SLOTS): latched slot index.
- `slot_valid` out NUM_SLOTS: per-slot key-present bits.
- `slot_lock` out NUM_SLOTS: per-slot write-protect bits.
- `resp_done` out 1: one-cycle response pulse.
- `resp_err` out 3: 0 OK, 1 CMD, 2 SIZE, 3 STATE, 4 TIMEOUT. Valid only with `resp_done`; 0 otherwise.

## Operation
- States: IDLE, CHECK, RD_XFER, WR_XFER, DONE, ERR. Register `err_code` (3 bits) selects the ERR response.
- IDLE: `cmd_rdy`=1. On `cmd_en`, latch `cmd_op`, `cmd_extend`, `wr_size` and go to CHECK.
- CHECK evaluates in this priority; the first match wins:
  - Opcode >3, or slot ≥ `NUM_SLOTS` → ERR/CMD.
  - Read:
    - `wr_size`≠0, `cmd_extend`=0, or `cmd_extend`>`SLOT_BYTES` → ERR/SIZE.
    - Slot not valid → ERR/STATE.
    - Otherwise load `remaining`=`cmd_extend` and go to RD_XFER.
  - Write:
    - `cmd_extend`≠0, `wr_size`=0, or `wr_size`>`SLOT_BYTES` → ERR/SIZE.
    - Slot locked → ERR/STATE.
    - Otherwise clear the slot's valid bit, load `remaining`=`wr_size` and go to WR_XFER.
  - Erase:
    - Either size ≠0 → ERR/SIZE.
    - Locked → ERR/STATE.
    - Otherwise clear valid and go to DONE.
  - Lock:
    - Either size ≠0 → ERR/SIZE.
    - Not valid → ERR/STATE.
    - Otherwise set lock and go to DONE.
- RD_XFER counts beats on `rd_en`; WR_XFER counts beats on `wr_en`. Per beat: `remaining` = (`remaining` ≤ `BEAT_BYTES`) ? 0 : `remaining` − `BEAT_BYTES`. This is 16-bit, with no wrap below 0.
- A transfer state with `remaining`=0 goes to DONE. For a write, the slot's valid bit is set on that same transition.
- Beats outside the matching XFER state are ignored.
- Watchdog:
  - Counter is cleared on entering an XFER state and on each beat, and increments otherwise.
  - At `TIMEOUT`−1 with no beat → ERR/TIMEOUT.
  - The slot of an aborted write stays invalid.
- DONE/ERR: `resp_done`=1 for one cycle, then IDLE.
- `clr_ssk`: next state IDLE; all `slot_valid`/`slot_lock` are cleared; no response.
- `ss_expire`: next state IDLE; slot bits are retained, except a write in progress leaves its slot invalid; no response. Both asserted: `clr_ssk` effect applies.
- `clr_ssk`/`ss_expire` take priority over every FSM transition, including a final beat in the same cycle.

## Timing
- Reset: state IDLE; `slot_valid`, `slot_lock`, `remaining`, watchdog, `slot_sel` and `err_code` are all 0.
- Output values out of reset: `cmd_rdy`=1; every other output is 0.
- All control outputs decode from registered state (Moore). Slot bits are registered.
- `cmd_en` at cycle N:
  - CHECK at N+1.
  - Erase, lock and errors: `resp_done` at N+2.
  - Transfers: `wr_open`/`rd_open` from N+2.
- Final beat at cycle M: DONE at M+1 (`resp_done`; `slot_valid` updated at M+1); IDLE and `cmd_rdy` at M+2.
- `cmd_en` outside IDLE is ignored.

## Structure
- Shared package `ssk_pkg` holds:
  - Opcode constants.
  - `resp_err` codes (ERR_OK/CMD/SIZE/STATE/TIMEOUT).
  - The one-hot state encodings.
- One natural sub-module is `ssk_beat_cnt`: it holds `remaining` with load, saturating decrement, a zero flag, and the watchdog counter. The FSM and slot-state registers stay in the top.

## Test plan
- Write slot 2, `wr_size`=10, `BEAT_BYTES`=4: three `wr_en` beats → `remaining` 6, 2, 0; `resp_done`, `resp_err`=0; `slot_valid`=4'b0100.
- Read slot 2, `cmd_extend`=65 (> `SLOT_BYTES` 64) → `resp_done` at N+2, `resp_err`=2. Read slot 1 (empty), `cmd_extend`=8 → `resp_err`=3.
- Lock slot 2, then write slot 2, `wr_size`=4 → `resp_err`=3, `slot_valid[2]` still 1. Erase slot 2 → `resp_err`=3.
- Opcode 5, or slot 7 with `NUM_SLOTS`=4 → `resp_err`=1 at N+2; `cmd_rdy` back high at N+3.
- Write of 8 bytes with one beat then idle: `TIMEOUT`−1 idle cycles → `resp_err`=4; `slot_valid` bit is 0.
- Mid-read `ss_expire` → IDLE next cycle, no `resp_done`, slots retained. `clr_ssk` → all valid/lock bits 0. `rst` asserted mid-write → all outputs at reset values next cycle.
